// File: rtl/i2c_target_regs_if.sv
// Host-side connection of the I2C target: register load port, write-commit report and status.
interface i2c_target_regs_if #(
  parameter int NREG_LOG2 = 5
);
  logic                 ld_en;
  logic [NREG_LOG2-1:0] ld_addr;
  logic [7:0]           ld_data;
  logic                 wr_strobe;
  logic [NREG_LOG2-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 busy;
  logic [NREG_LOG2-1:0] ptr;

  modport slave (
    input  ld_en, ld_addr, ld_data,
    output wr_strobe, wr_addr, wr_data, busy, ptr
  );

  modport master (
    output ld_en, ld_addr, ld_data,
    input  wr_strobe, wr_addr, wr_data, busy, ptr
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target answering DEV_ADDR with a byte register file, auto-incrementing pointer
// and a host load port. The SDA/SCL pins stay plain ports so the open-drain net resolves cleanly.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR  = 7'h29,
  parameter int         NREG_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  i2c_target_regs_if.slave host
);
  localparam int NREG = 2 ** NREG_LOG2;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t               r_state, w_state_next;
  logic [1:0]           r_scl_sync, r_sda_sync;
  logic [2:0]           r_scl_hist, r_sda_hist;
  logic                 r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
  logic [1:0]           r_fall_dly;
  logic [2:0]           r_cnt, w_cnt_next;
  logic [7:0]           r_shift, w_shift_next;
  logic [NREG_LOG2-1:0] r_ptr, w_ptr_next, w_ptr_inc;
  logic                 r_busy, w_busy_next;
  logic                 r_rw, w_rw_next;
  logic                 r_sda_oe, w_sda_oe_next;
  logic                 r_wr_strobe;
  logic [NREG_LOG2-1:0] r_wr_addr;
  logic [7:0]           r_wr_data;
  logic                 w_commit;
  logic [7:0]           w_byte;
  logic [7:0]           r_regs [NREG];
  logic                 w_scl_rise, w_scl_fall, w_start, w_stop, w_drive;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Synchronizers and filters idle high so reset never fabricates a bus event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_fd   <= 1'b1;
      r_sda_fd   <= 1'b1;
      r_fall_dly <= 2'b00;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
      r_scl_f    <= maj3(r_scl_hist);
      r_sda_f    <= maj3(r_sda_hist);
      r_scl_fd   <= r_scl_f;
      r_sda_fd   <= r_sda_f;
      r_fall_dly <= {r_fall_dly[0], w_scl_fall};
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  assign w_start    = r_scl_f & r_scl_fd & ~r_sda_f & r_sda_fd;
  assign w_stop     = r_scl_f & r_scl_fd & r_sda_f & ~r_sda_fd;
  assign w_drive    = r_fall_dly[1];
  assign w_byte     = {r_shift[6:0], r_sda_f};
  assign w_ptr_inc  = r_ptr + NREG_LOG2'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_ptr       <= w_ptr_next;
      r_busy      <= w_busy_next;
      r_rw        <= w_rw_next;
      r_sda_oe    <= w_sda_oe_next;
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
    end
  end

  // Bits are taken on SCL rise; SDA is only updated on the delayed SCL fall.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_shift_next  = r_shift;
    w_ptr_next    = r_ptr;
    w_busy_next   = r_busy;
    w_rw_next     = r_rw;
    w_sda_oe_next = r_sda_oe;
    w_commit      = 1'b0;
    if (w_start) begin
      w_state_next  = S_ADDR;
      w_cnt_next    = '0;
      w_sda_oe_next = 1'b0;
    end else if (w_stop) begin
      w_state_next  = S_IDLE;
      w_sda_oe_next = 1'b0;
      w_busy_next   = 1'b0;
    end else begin
      if (w_drive) begin
        case (r_state)
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: w_sda_oe_next = 1'b1;
          S_RDATA:                            w_sda_oe_next = ~r_shift[7];
          default:                            w_sda_oe_next = 1'b0;
        endcase
      end
      if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            w_shift_next = w_byte;
            w_cnt_next   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              case (r_state)
                S_ADDR: begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    w_state_next = S_ADDR_ACK;
                    w_busy_next  = 1'b1;
                    w_rw_next    = w_byte[0];
                  end else begin
                    w_state_next  = S_WAIT_STOP;
                    w_sda_oe_next = 1'b0;
                  end
                end
                S_REG: begin
                  w_ptr_next   = w_byte[NREG_LOG2-1:0];
                  w_state_next = S_REG_ACK;
                end
                default: begin
                  w_commit     = 1'b1;
                  w_ptr_next   = w_ptr_inc;
                  w_state_next = S_WDATA_ACK;
                end
              endcase
            end
          end
          S_ADDR_ACK: begin
            w_cnt_next = '0;
            if (r_rw) begin
              w_shift_next = r_regs[r_ptr];
              w_state_next = S_RDATA;
            end else begin
              w_state_next = S_REG;
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            w_cnt_next   = '0;
            w_state_next = S_WDATA;
          end
          S_RDATA: begin
            w_shift_next = {r_shift[6:0], 1'b1};
            w_cnt_next   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_state_next = S_RDATA_ACK;
          end
          S_RDATA_ACK: begin
            if (!r_sda_f) begin
              w_ptr_next   = w_ptr_inc;
              w_shift_next = r_regs[w_ptr_inc];
              w_cnt_next   = '0;
              w_state_next = S_RDATA;
            end else begin
              w_state_next = S_WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // An I2C commit outranks a host load to the same register in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_regs[gi] <= 8'h00;
        else if (w_commit && (r_ptr == NREG_LOG2'(gi)))
          r_regs[gi] <= w_byte;
        else if (host.ld_en && (host.ld_addr == NREG_LOG2'(gi)))
          r_regs[gi] <= host.ld_data;
      end
    end
  endgenerate

  assign sda            = r_sda_oe ? 1'b0 : 1'bz;
  assign host.wr_strobe = r_wr_strobe;
  assign host.wr_addr   = r_wr_addr;
  assign host.wr_data   = r_wr_data;
  assign host.busy      = r_busy;
  assign host.ptr       = r_ptr;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a register-file model.
module tb_i2c_target_regs;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_regs_if #(.NREG_LOG2(5)) bus ();

  i2c_target_regs #(.DEV_ADDR(7'h29), .NREG_LOG2(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (m_scl),
    .sda  (sda),
    .host (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_regs [32];
  logic [4:0]  model_ptr;
  logic [12:0] strobe_q [$];

  always @(negedge clk)
    if (rst && bus.wr_strobe) strobe_q.push_back({bus.wr_addr, bus.wr_data});

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    m_sda_low = ~b;
    wq();
    m_scl = 1'b1;
    wq();
    s = sda;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; m_scl = 1'b1; wq();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda_low = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(nack, s);
  endtask

  task automatic host_load(input logic [4:0] a, input logic [7:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
    model_regs[a] = d;
  endtask

  // Write transaction: pointer byte (upper bits are noise) followed by n data bytes.
  task automatic txn_write(input logic [4:0] p, input logic [7:0] cmd_hi, input int n,
                           input logic [7:0] d [4]);
    logic        ack;
    logic [7:0]  rb;
    logic [12:0] exp_q [$];
    strobe_q.delete();
    rb = {cmd_hi[7:5], p};
    i2c_start();
    wr_byte(8'h52, ack); check("w_addr_ack", ack, 0);
    wr_byte(rb, ack);    check("w_reg_ack", ack, 0);
    model_ptr = p;
    for (int i = 0; i < n; i++) begin
      wr_byte(d[i], ack);
      check("w_data_ack", ack, 0);
      model_regs[model_ptr] = d[i];
      exp_q.push_back({model_ptr, d[i]});
      model_ptr = model_ptr + 5'd1;
    end
    i2c_stop();
    wq();
    check("w_strobe_count", strobe_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < strobe_q.size()) check("w_strobe", strobe_q[i], exp_q[i]);
    check("w_ptr", bus.ptr, model_ptr);
    check("w_busy_after", bus.busy, 0);
  endtask

  task automatic txn_read(input logic [4:0] p, input int n, output logic [7:0] got [4]);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    wr_byte(8'h52, ack);     check("r_waddr_ack", ack, 0);
    wr_byte({3'b000, p}, ack); check("r_reg_ack", ack, 0);
    i2c_rstart();
    wr_byte(8'h53, ack);     check("r_raddr_ack", ack, 0);
    check("r_busy_mid", bus.busy, 1);
    model_ptr = p;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, b);
      got[i] = b;
      check("r_data", b, model_regs[model_ptr]);
      if (i < n - 1) model_ptr = model_ptr + 5'd1;
    end
    check("r_sda_released", sda, 1);
    i2c_stop();
    wq();
    check("r_busy_after", bus.busy, 0);
    check("r_ptr", bus.ptr, model_ptr);
  endtask

  initial begin
    logic [7:0] wd [4];
    logic [7:0] rd [4];
    logic       ack;
    logic       seen;
    logic [7:0] b;
    logic [4:0] rp;
    int         rn;

    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    model_ptr = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ptr", bus.ptr, 0);
    check("rst_wr_strobe", bus.wr_strobe, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_sda", sda, 1);

    for (int i = 0; i < 32; i++) host_load(5'(i), 8'($urandom));

    // Two-byte sensor read with repeated start.
    host_load(5'h16, 8'hA5);
    host_load(5'h17, 8'h3C);
    txn_read(5'h16, 2, rd);
    $display("read2 ptr=16 data_out=%h", {rd[1], rd[0]});
    check("read2_data_out", {rd[1], rd[0]}, 16'h3CA5);
    check("read2_ptr", bus.ptr, 5'h17);

    // Foreign address is not acknowledged.
    strobe_q.delete();
    i2c_start();
    wr_byte(8'h60, ack);
    check("nomatch_ack_high", ack, 1);
    check("nomatch_busy", bus.busy, 0);
    i2c_stop();
    wq();
    check("nomatch_strobes", strobe_q.size(), 0);
    check("nomatch_ptr", bus.ptr, model_ptr);
    $display("write to 0x30 ack=%b busy=%b", ack, bus.busy);

    // Multi-byte write wrapping the pointer.
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h00; wd[3] = 8'h00;
    txn_write(5'h1F, 8'h80, 2, wd);
    check("wrap_ptr", bus.ptr, 5'h01);
    $display("write 1F: 11 22 ptr=%h", bus.ptr);

    // Read across the wrap boundary.
    txn_read(5'h1E, 3, rd);
    $display("read3 ptr=1E: %h %h %h", rd[0], rd[1], rd[2]);

    // Host load colliding with an I2C commit to the same register.
    strobe_q.delete();
    i2c_start();
    wr_byte(8'h52, ack); check("coll_addr_ack", ack, 0);
    wr_byte(8'h05, ack); check("coll_reg_ack", ack, 0);
    seen = 1'b0;
    fork
      wr_byte(8'h99, ack);
      begin
        bus.ld_addr = 5'h05; bus.ld_data = 8'h77; bus.ld_en = 1'b1;
        for (int k = 0; k < 800 && !seen; k++) begin
          @(negedge clk);
          if (bus.wr_strobe) seen = 1'b1;
        end
        bus.ld_en = 1'b0;
      end
    join
    check("coll_strobe_seen", seen, 1);
    check("coll_data_ack", ack, 0);
    i2c_stop();
    wq();
    model_regs[5] = 8'h99;
    model_ptr = 5'h06;
    check("coll_strobe_count", strobe_q.size(), 1);
    txn_read(5'h05, 1, rd);
    check("coll_reg05", rd[0], 8'h99);
    $display("collision reg05=%h", rd[0]);

    // Randomized writes and reads against the model.
    for (int t = 0; t < 6; t++) begin
      rp = 5'($urandom);
      rn = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
        txn_write(rp, 8'($urandom), rn, wd);
        $display("rand write ptr=%h n=%0d", rp, rn);
      end else begin
        txn_read(rp, rn, rd);
        $display("rand read ptr=%h n=%0d first=%h", rp, rn, rd[0]);
      end
    end

    // Reset while the target is driving a 0 data bit.
    host_load(5'h08, 8'h0F);
    i2c_start();
    wr_byte(8'h52, ack); check("rstmid_waddr_ack", ack, 0);
    wr_byte(8'h08, ack); check("rstmid_reg_ack", ack, 0);
    i2c_rstart();
    wr_byte(8'h53, ack); check("rstmid_raddr_ack", ack, 0);
    m_sda_low = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    check("rstmid_sda_driven", sda, 0);
    #2 rst = 1'b0;
    #1;
    check("rstmid_sda_released", sda, 1);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_ptr", bus.ptr, 0);
    check("rstmid_wr_strobe", bus.wr_strobe, 0);
    check("rstmid_wr_addr", bus.wr_addr, 0);
    check("rstmid_wr_data", bus.wr_data, 0);
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    model_ptr = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    i2c_start();
    wr_byte(8'h53, ack); check("postrst_addr_ack", ack, 0);
    rd_byte(1'b1, b);
    check("postrst_reg00", b, model_regs[0]);
    i2c_stop();
    wq();
    check("postrst_busy", bus.busy, 0);
    $display("post-reset read reg00=%h", b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) responder for the sensor-readout path. It answers a master at DEV_ADDR with a 32-byte register file, so `i2c_master_read2bytes` can be exercised end to end in simulation and on loopback hardware.
- Supports the write-pointer and repeated-start read sequence used for two-byte sensor reads, multi-byte writes, and pointer auto-increment.
- A host-side load port lets the design refresh register contents (for example, emulated colour-channel data).

Parameters:
DEV_ADDR, 7'h29, 7-bit I2C address the block responds to.
NREG_LOG2, 5, log2 of register count (32 bytes); pointer width.

Ports:
clk  in  1  system clock (50 MHz; must be at least 16x the SCL frequency).
rst  in  1  asynchronous active-low reset.
scl  in  1  I2C clock from the master (pulled up externally).
sda  inout  1  open-drain data line; the block drives only 1'b0 or 1'bz.
ld_en  in  1  host load strobe, one cycle.
ld_addr  in  NREG_LOG2  host load register index.
ld_data  in  8  host load data.
wr_strobe  out  1  one-cycle pulse when an I2C write commits a data byte.
wr_addr  out  NREG_LOG2  register written on the wr_strobe cycle.
wr_data  out  8  byte written on the wr_strobe cycle.
busy  out  1  high from an address-matched START until the following STOP.
ptr  out  NREG_LOG2  current register pointer.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, sda released (z), busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all registers=8'h00.
  - Reset mid-transfer releases sda immediately.
- Input conditioning and bus events:
  - scl and sda each pass through a 2-FF synchronizer plus a 3-sample majority filter; edges are detected on the filtered values.
  - START or repeated start: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high.
  - Events are taken from any state: START goes to ADDR with bit counter cleared; STOP goes to IDLE, releases sda and clears busy.
- Sampling and driving:
  - Bits are sampled on the SCL rising edge, MSB first.
  - sda changes only 2 clk after an SCL falling edge (hold time).
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits (7-bit address + R/W).
    - Address match: go to ADDR_ACK, set busy=1.
    - Mismatch: go to WAIT_STOP with sda released.
  - ADDR_ACK: drive 0 for one SCL period.
    - R/W=0: go to REG if this is the first write byte after START, else WDATA.
    - R/W=1: load shift register with reg[ptr], go to RDATA.
  - REG: 8 bits, ptr <= byte[NREG_LOG2-1:0]; the upper bits are ignored (the command bit 0x80 is ignored). Go to REG_ACK (drive 0), then WDATA.
  - WDATA: 8 bits, then WDATA_ACK.
    - Drive 0; reg[ptr] <= byte; wr_strobe pulses with wr_addr=ptr, wr_data=byte; ptr++.
    - Return to WDATA.
  - RDATA: drive each bit of the shift register (drive 0 for a 0 bit, z for a 1 bit). Go to RDATA_ACK and release sda.
  - RDATA_ACK: sample the master's bit on SCL rise.
    - ACK (0): ptr++, reload the shift register with the new reg[ptr], go to RDATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: sda released; waits for START or STOP.
- Pointer:
  - Wraps from 2^NREG_LOG2-1 to 0 on increment.
  - The pointer persists across transactions and is cleared only by reset.
- Load-port collision:
  - ld_en writes reg[ld_addr] in any state.
  - If it hits the same register on the same cycle as an I2C write commit, the I2C write wins.
  - A load to the register currently held in the read shift register does not alter the byte in flight.

Test Plan:
- Preload 0x16=8'hA5, 0x17=8'h3C. Master sends START, 0x52, 0x16, Sr, 0x53, reads 2 bytes (ACK, NACK), then STOP -> target ACKs the three header bytes, bus carries A5 then 3C, master data_out=16'h3CA5, busy returns to 0 after STOP, ptr=0x17.
- Write to address 0x30 (0x60) -> no ACK (SDA stays high at bit 9), busy stays 0, registers unchanged.
- Write 0x52, 0x1F, then data 0x11, 0x22 -> wr_strobe pulses for (0x1F, 0x11) and (0x00, 0x22); ptr wraps to 0x01.
- Read of 3 bytes from ptr 0x1E with ACK, ACK, NACK -> bytes reg[0x1E], reg[0x1F], reg[0x00]; sda released after the NACK.
- ld_en to 0x05 with 0x77 in the same cycle as an I2C commit to 0x05 of 0x99 -> reg[0x05]=0x99.
- rst asserted in the middle of an RDATA bit driving 0 -> sda goes to z the same cycle, all outputs return to reset values, and the next START with 0x53 reads reg[0x00]=0x00.
